slide_puzzle_ctrl: RTL

Parametrised N x N sliding-tile puzzle engine, the generalised successor of the fixed 2x2 play controller. It holds the live board, loads a start board during board selection, inserts the blank, and applies legal blank moves from direction requests. It also counts moves and flags a solved board. It sits between the input/debounce logic and the display/board-render logic, driven by the top-level game status FSM.

---
 rtl/slide_puzzle_pkg.sv | 38 +++
 rtl/slide_puzzle_win_det.sv | 38 +++
 rtl/slide_puzzle_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/slide_puzzle_pkg.sv
// Shared definitions for the N x N sliding-tile puzzle engine: game status codes,
// blank-move direction bit indices and board-generation helpers.
package slide_puzzle_pkg;

  typedef enum logic [1:0] {
    GS_CHOSE_BOARD  = 2'b00,
    GS_GAMING       = 2'b01,
    GS_GAME_INITIAL = 2'b10,
    GS_WINNED       = 2'b11
  } game_status_e;

  localparam int DIR_UP    = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 3;

  // Widest board the helpers can build: 4x4 cells of 5 bits.
  localparam int MAX_BW = 80;

  function automatic int blank_code(input int n);
    return n * n;
  endfunction

  // Identity board (cell k = k), cell 0 in the MSBs, right-aligned in MAX_BW bits.
  function automatic logic [MAX_BW-1:0] default_board(input int n, input int cw);
    logic [MAX_BW-1:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < n * n) begin
        res = (res << cw) | MAX_BW'(k);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/slide_puzzle_win_det.sv
// Combinational solved-board check: exactly one BLANK cell and every other
// cell k holding code k. Out-of-range codes simply fail the check.
module slide_puzzle_win_det
  import slide_puzzle_pkg::*;
#(
  parameter int N      = 2,
  parameter int CELL_W = $clog2(N*N+1)
) (
  input  logic [N*N*CELL_W-1:0] board_i,
  output logic                  win_o
);

  localparam int NC   = N * N;
  localparam int BC_W = $clog2(NC + 1);
  localparam logic [CELL_W-1:0] BLANK_C = CELL_W'(blank_code(N));

  logic [BC_W-1:0]   blank_cnt_s;
  logic              cells_ok_s;
  logic [CELL_W-1:0] cell_s;

  always_comb begin
    blank_cnt_s = '0;
    cells_ok_s  = 1'b1;
    cell_s      = '0;
    for (int k = 0; k < NC; k++) begin
      cell_s = board_i[(NC-1-k)*CELL_W +: CELL_W];
      if (cell_s == BLANK_C) begin
        blank_cnt_s = blank_cnt_s + BC_W'(1);
      end else if (cell_s != CELL_W'(k)) begin
        cells_ok_s = 1'b0;
      end else begin
        cells_ok_s = cells_ok_s;
      end
    end
    win_o = cells_ok_s && (blank_cnt_s == BC_W'(1));
  end

endmodule

// File: rtl/slide_puzzle_ctrl.sv
// N x N sliding-tile puzzle engine: board load, blank insertion, prioritised
// blank moves, saturating move counter and registered solved flag.
// Optional macro SLIDE_PUZZLE_ACT_EDGE_EN: act treated as rising-edge requests.
module slide_puzzle_ctrl
  import slide_puzzle_pkg::*;
#(
  parameter int N          = 2,
  parameter int CELL_W     = $clog2(N*N+1),
  parameter int BLANK_INIT = N*(N-1),
  parameter int CNT_W      = 10
) (
  input  logic                     clk_d,
  input  logic                     reset,
  input  logic [1:0]               game_status,
  input  logic [3:0]               act,
  input  logic [N*N*CELL_W-1:0]    origin_board,
  output logic [N*N*CELL_W-1:0]    out,
  output logic [$clog2(N*N)-1:0]   blank_pos,
  output logic [CNT_W-1:0]         move_count,
  output logic                     move_valid,
  output logic                     win_flag
);

  localparam int NC = N * N;
  localparam int BW = NC * CELL_W;
  localparam int PW = $clog2(NC);
  localparam logic [CELL_W-1:0] BLANK_C      = CELL_W'(blank_code(N));
  localparam logic [BW-1:0]     DEFAULT_BD   = BW'(default_board(N, CELL_W));
  localparam logic [PW-1:0]     BLANK_INIT_P = PW'(BLANK_INIT);
  localparam logic [PW-1:0]     N_P          = PW'(N);

  game_status_e   gs_s;
  logic [BW-1:0]  origin_q, origin_d;
  logic [BW-1:0]  board_q, board_d;
  logic [PW-1:0]  blank_q, blank_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           win_q, win_s;
  logic [3:0]     req_s, legal_s, cand_s;
  logic [PW-1:0]  col_s, tgt_s;

  assign gs_s = game_status_e'(game_status);

`ifdef SLIDE_PUZZLE_ACT_EDGE_EN
  logic [3:0] act_q;

  // Previous act sample, so a held button yields a single request.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      act_q <= 4'b0000;
    end else begin
      act_q <= act;
    end
  end

  assign req_s = act & ~act_q;
`else
  assign req_s = act;
`endif

  assign col_s              = blank_q % N_P;
  assign legal_s[DIR_UP]    = blank_q >= N_P;
  assign legal_s[DIR_RIGHT] = col_s != PW'(N - 1);
  assign legal_s[DIR_DOWN]  = blank_q < PW'(NC - N);
  assign legal_s[DIR_LEFT]  = col_s != '0;
  assign cand_s             = req_s & legal_s;

  // Lowest-index request that is also legal picks the swap target.
  always_comb begin
    tgt_s = blank_q;
    casez (cand_s)
      4'b???1: tgt_s = blank_q - N_P;
      4'b??10: tgt_s = blank_q + PW'(1);
      4'b?100: tgt_s = blank_q + N_P;
      4'b1000: tgt_s = blank_q - PW'(1);
      default: tgt_s = blank_q;
    endcase
  end

  always_comb begin
    origin_d = origin_q;
    board_d  = board_q;
    blank_d  = blank_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    case (gs_s)
      GS_CHOSE_BOARD: origin_d = origin_board;
      GS_GAME_INITIAL: begin
        board_d = origin_q;
        board_d[(NC-1-BLANK_INIT)*CELL_W +: CELL_W] = BLANK_C;
        blank_d = BLANK_INIT_P;
        cnt_d   = '0;
      end
      GS_GAMING: begin
        if (|cand_s) begin
          board_d[(NC-1-int'(blank_q))*CELL_W +: CELL_W] =
            board_q[(NC-1-int'(tgt_s))*CELL_W +: CELL_W];
          board_d[(NC-1-int'(tgt_s))*CELL_W +: CELL_W] = BLANK_C;
          blank_d = tgt_s;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      GS_WINNED: begin
        origin_d = DEFAULT_BD;
        blank_d  = BLANK_INIT_P;
      end
      default: valid_d = 1'b0;
    endcase
  end

  slide_puzzle_win_det #(
    .N      (N),
    .CELL_W (CELL_W)
  ) u_win_det (
    .board_i (board_q),
    .win_o   (win_s)
  );

  // Game state registers; the solved flag lags the board by one cycle.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      origin_q <= DEFAULT_BD;
      board_q  <= DEFAULT_BD;
      blank_q  <= BLANK_INIT_P;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      origin_q <= origin_d;
      board_q  <= board_d;
      blank_q  <= blank_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      win_q    <= win_s;
    end
  end

  assign out        = board_q;
  assign blank_pos  = blank_q;
  assign move_count = cnt_q;
  assign move_valid = valid_q;
  assign win_flag   = win_q;

endmodule
